// File: rtl/commonlib_muxn_pkg.sv
// Shared helpers for the pipelined mux tree: select width and stage geometry.
// Used by both the RTL and the testbench so they agree on stage layout.
package commonlib_muxn_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int num_stages(input int levels, input int reg_every);
    return (levels + reg_every - 1) / reg_every;
  endfunction

  function automatic int stage_last_level(input int s, input int reg_every, input int levels);
    int hi;
    hi = (s + 1) * reg_every;
    if (hi > levels) hi = levels;
    return hi - 1;
  endfunction

  // Payload held by stage s: surviving partial words plus the select bits still to be used.
  function automatic int stage_payload_w(input int s, input int sel_w, input int reg_every,
                                         input int width);
    int rem;
    rem = sel_w - stage_last_level(s, reg_every, sel_w) - 1;
    return (1 << rem) * width + rem;
  endfunction

  function automatic int stage_payload_off(input int s, input int sel_w, input int reg_every,
                                           input int width);
    int off;
    off = 0;
    for (int t = 0; t < s; t++) off += stage_payload_w(t, sel_w, reg_every, width);
    return off;
  endfunction

endpackage

// File: rtl/commonlib_muxn_pipe_if.sv
// Stream bundle of the pipelined N-way mux: input word vector + select, output word,
// flush and the sticky select-error flag.
interface commonlib_muxn_pipe_if #(
  parameter int N     = 8,
  parameter int WIDTH = 8
);
  localparam int SEL_W = commonlib_muxn_pkg::clog2(N);

  logic                 flush;
  logic [N*WIDTH-1:0]   in_data;
  logic [SEL_W-1:0]     in_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 sel_err;

  modport master (
    output flush, in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );

  modport slave (
    input  flush, in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );

endinterface

// File: rtl/commonlib_muxn_pipe_stage.sv
// One elastic register slice: holds a payload word with its valid bit and
// chains ready backwards so the pipeline runs at one transfer per cycle.
module commonlib_muxn_pipe_stage #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          flush,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [PW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [PW-1:0] dn_data
);

  assign up_ready = !dn_valid || dn_ready;

  // Flush drops the valid but deliberately leaves the data register untouched.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (flush) begin
      dn_valid <= 1'b0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
  end

endmodule

// File: rtl/commonlib_muxn_pipe.sv
// Pipelined N-way WIDTH-bit mux tree with valid/ready handshake; the select travels
// with the data. Optional sticky range check enabled by COMMONLIB_MUXN_PIPE_SEL_CHECK_EN.
module commonlib_muxn_pipe
  import commonlib_muxn_pkg::*;
#(
  parameter int N         = 8,
  parameter int WIDTH     = 8,
  parameter int REG_EVERY = 1
) (
  input logic                  clk,
  input logic                  arst_n,
  commonlib_muxn_pipe_if.slave bus
);

  localparam int SEL_W   = clog2(N);
  localparam int LEVELS  = SEL_W;
  localparam int STAGES  = num_stages(LEVELS, REG_EVERY);
  localparam int TOTAL_W = stage_payload_off(STAGES, SEL_W, REG_EVERY, WIDTH);

  logic [STAGES:0]    rdy;
  logic [STAGES-1:0]  vld;
  logic [TOTAL_W-1:0] q_bus;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO        = s * REG_EVERY;
    localparam int HI        = stage_last_level(s, REG_EVERY, LEVELS);
    localparam int NL        = HI - LO + 1;
    localparam int IN_SW     = SEL_W - LO;
    localparam int OUT_SW    = SEL_W - HI - 1;
    localparam int IN_WORDS  = 1 << IN_SW;
    localparam int OUT_WORDS = 1 << OUT_SW;
    localparam int PW        = stage_payload_w(s, SEL_W, REG_EVERY, WIDTH);
    localparam int OFF       = stage_payload_off(s, SEL_W, REG_EVERY, WIDTH);

    logic [IN_WORDS*WIDTH-1:0] d_in;
    logic [IN_WORDS*WIDTH-1:0] work;
    logic [IN_SW-1:0]          s_in;
    logic [PW-1:0]             d_next;
    logic                      up_valid;

    if (s == 0) begin : g_first
      // Missing inputs of a non-power-of-two N read as zero, so out-of-range selects yield 0.
      always_comb begin
        d_in = '0;
        d_in[N*WIDTH-1:0] = bus.in_data;
      end
      assign s_in     = bus.in_sel;
      assign up_valid = bus.in_valid;
    end else begin : g_rest
      localparam int POFF = stage_payload_off(s - 1, SEL_W, REG_EVERY, WIDTH);
      localparam int PPW  = stage_payload_w(s - 1, SEL_W, REG_EVERY, WIDTH);
      assign {s_in, d_in} = q_bus[POFF +: PPW];
      assign up_valid     = vld[s-1];
    end

    // Each level halves the word count in place; level l of this slice uses the residual sel LSB first.
    always_comb begin
      work = d_in;
      for (int l = 0; l < NL; l++) begin
        for (int k = 0; k < (IN_WORDS >> (l + 1)); k++) begin
          work[k*WIDTH +: WIDTH] = s_in[l] ? work[(2*k+1)*WIDTH +: WIDTH]
                                           : work[(2*k)*WIDTH +: WIDTH];
        end
      end
    end

    if (OUT_SW > 0) begin : g_carry_sel
      assign d_next = {s_in[IN_SW-1:NL], work[OUT_WORDS*WIDTH-1:0]};
    end else begin : g_final
      assign d_next = work[WIDTH-1:0];
    end

    commonlib_muxn_pipe_stage #(.PW(PW)) u_stage (
      .clk      (clk),
      .arst_n   (arst_n),
      .flush    (bus.flush),
      .up_valid (up_valid),
      .up_ready (rdy[s]),
      .up_data  (d_next),
      .dn_valid (vld[s]),
      .dn_ready (rdy[s+1]),
      .dn_data  (q_bus[OFF +: PW])
    );
  end

  assign rdy[STAGES]   = bus.out_ready;
  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld[STAGES-1];
  assign bus.out_data  = q_bus[TOTAL_W-WIDTH +: WIDTH];

`ifdef COMMONLIB_MUXN_PIPE_SEL_CHECK_EN
  logic sel_err_q;

  // Sticky until reset; flush does not clear it.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sel_err_q <= 1'b0;
    end else if (bus.in_valid && rdy[0] && ({1'b0, bus.in_sel} >= (SEL_W + 1)'(N))) begin
      sel_err_q <= 1'b1;
    end
  end

  assign bus.sel_err = sel_err_q;
`else
  assign bus.sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_commonlib_muxn_pipe.sv
// Scoreboard bench for commonlib_muxn_pipe: an 8-way/REG_EVERY=1 instance and a
// 5-way/REG_EVERY=2 instance, directed vectors with hand-computed expectations.
module tb_commonlib_muxn_pipe;

`ifdef COMMONLIB_MUXN_PIPE_SEL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk;
  logic arst_n;
  int   n_checks;
  int   n_fail;
  int   cyc;

  typedef struct {
    logic [7:0] data;
    int         acc;
    int         lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  logic [7:0] hold_a;
  logic [7:0] hold_b;
  bit         stall_a;
  bit         stall_b;

  commonlib_muxn_pipe_if #(.N(8), .WIDTH(8)) ia ();
  commonlib_muxn_pipe_if #(.N(5), .WIDTH(8)) ib ();

  commonlib_muxn_pipe #(.N(8), .WIDTH(8), .REG_EVERY(1)) u_dut_a (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (ia)
  );

  commonlib_muxn_pipe #(.N(5), .WIDTH(8), .REG_EVERY(2)) u_dut_b (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushExp(input bit is_b, input logic [7:0] data, input int lat);
    exp_t e;
    e.data = data;
    e.acc  = cyc;
    e.lat  = lat;
    if (is_b) qb.push_back(e);
    else      qa.push_back(e);
  endtask

  // Present one word and wait (bounded) for its acceptance; expected value is queued on acceptance.
  task automatic applyStimulus(input bit is_b, input logic [2:0] sel, input logic [7:0] exp,
                               input int lat);
    bit accepted;
    accepted = 1'b0;
    if (is_b) begin ib.in_valid = 1'b1; ib.in_sel = sel; end
    else      begin ia.in_valid = 1'b1; ia.in_sel = sel; end
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(negedge clk);
      if (is_b ? ib.in_ready : ia.in_ready) begin
        accepted = 1'b1;
        pushExp(is_b, exp, lat);
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: sel %0d on dut %0d never accepted", sel, is_b);
    end
  endtask

  task automatic idleInputs();
    ia.in_valid = 1'b0;
    ib.in_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitors: pop and compare on every output transfer, and check data holds while stalled.
  always @(negedge clk) begin
    if (arst_n) begin
      if (ia.out_valid && stall_a) checkOutput("a_hold", ia.out_data, hold_a);
      stall_a = ia.out_valid && !ia.out_ready;
      hold_a  = ia.out_data;
      if (ia.out_valid && ia.out_ready) begin
        if (qa.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL a_unexpected: got word 0x%0h, expected no output", ia.out_data);
        end else begin
          ea = qa.pop_front();
          checkOutput("a_data", ia.out_data, ea.data);
          if (ea.lat != 0) checkOutput("a_latency", cyc - ea.acc, ea.lat);
        end
      end
    end else begin
      stall_a = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (arst_n) begin
      if (ib.out_valid && stall_b) checkOutput("b_hold", ib.out_data, hold_b);
      stall_b = ib.out_valid && !ib.out_ready;
      hold_b  = ib.out_data;
      if (ib.out_valid && ib.out_ready) begin
        if (qb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL b_unexpected: got word 0x%0h, expected no output", ib.out_data);
        end else begin
          eb = qb.pop_front();
          checkOutput("b_data", ib.out_data, eb.data);
          if (eb.lat != 0) checkOutput("b_latency", cyc - eb.acc, eb.lat);
        end
      end
    end else begin
      stall_b = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_acc;
    int sel_k;
    int c0;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    arst_n   = 1'b0;
    ia.flush = 1'b0; ia.in_valid = 1'b0; ia.in_sel = '0; ia.out_ready = 1'b1;
    ib.flush = 1'b0; ib.in_valid = 1'b0; ib.in_sel = '0; ib.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) ia.in_data[i*8 +: 8] = 8'(8'h10 + i);
    for (int i = 0; i < 5; i++) ib.in_data[i*8 +: 8] = 8'(8'hA0 + i);

    waitCycles(2);
    arst_n = 1'b1;
    @(negedge clk);
    checkOutput("a_rst_out_valid", ia.out_valid, 0);
    checkOutput("a_rst_out_data",  ia.out_data,  0);
    checkOutput("a_rst_in_ready",  ia.in_ready,  1);
    checkOutput("a_rst_sel_err",   ia.sel_err,   0);
    checkOutput("b_rst_out_valid", ib.out_valid, 0);
    checkOutput("b_rst_in_ready",  ib.in_ready,  1);
    @(posedge clk);
    #1;

    $display("[TB] latency: sel=5 on 8-way instance");
    applyStimulus(0, 3'd5, 8'h15, 3);
    checkOutput("a_lat_in_ready", ia.in_ready, 1);
    idleInputs();
    waitCycles(5);

    $display("[TB] throughput: sel 0..7 back-to-back");
    c0 = cyc;
    for (int s = 0; s < 8; s++) applyStimulus(0, 3'(s), 8'(8'h10 + s), 3);
    checkOutput("a_stream_cycles", cyc - c0, 8);
    idleInputs();
    waitCycles(6);

    $display("[TB] backpressure: out_ready low for 5 cycles");
    ia.out_ready = 1'b0;
    n_acc = 0;
    sel_k = 1;
    ia.in_valid = 1'b1;
    ia.in_sel   = 3'd1;
    repeat (5) begin
      @(negedge clk);
      if (ia.in_ready) begin
        pushExp(0, 8'(8'h10 + sel_k), 0);
        n_acc++;
        sel_k++;
      end
      @(posedge clk);
      #1;
      ia.in_sel = 3'(sel_k);
    end
    checkOutput("a_bp_accepts",  n_acc, 3);
    checkOutput("a_bp_in_ready", ia.in_ready, 0);
    checkOutput("a_bp_out_data", ia.out_data, 8'h11);
    ia.out_ready = 1'b1;
    applyStimulus(0, 3'd4, 8'h14, 0);
    applyStimulus(0, 3'd5, 8'h15, 0);
    applyStimulus(0, 3'd6, 8'h16, 0);
    idleInputs();
    waitCycles(8);

    $display("[TB] range: 5-way instance, REG_EVERY=2");
    applyStimulus(1, 3'd4, 8'hA4, 2);
    applyStimulus(1, 3'd1, 8'hA1, 2);
    checkOutput("b_sel_err_pre", ib.sel_err, 0);
    applyStimulus(1, 3'd6, 8'h00, 2);
    checkOutput("b_sel_err_set", ib.sel_err, EXP_ERR);
    applyStimulus(1, 3'd3, 8'hA3, 2);
    applyStimulus(1, 3'd5, 8'h00, 2);
    applyStimulus(1, 3'd7, 8'h00, 2);
    idleInputs();
    waitCycles(5);
    checkOutput("b_sel_err_sticky", ib.sel_err, EXP_ERR);
    checkOutput("a_sel_err_pow2",   ia.sel_err, 0);

    $display("[TB] flush with three words in flight");
    ia.out_ready = 1'b0;
    applyStimulus(0, 3'd0, 8'h10, 0);
    applyStimulus(0, 3'd1, 8'h11, 0);
    applyStimulus(0, 3'd2, 8'h12, 0);
    ia.flush    = 1'b1;
    ia.in_valid = 1'b1;
    ia.in_sel   = 3'd7;
    @(posedge clk);
    #1;
    ia.flush = 1'b0;
    idleInputs();
    qa.delete();
    checkOutput("a_flush_out_valid", ia.out_valid, 0);
    ia.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("a_flush_quiet", ia.out_valid, 0);
    end
    checkOutput("a_flush_in_ready", ia.in_ready, 1);
    checkOutput("a_flush_data_kept", ia.out_data, 8'h10);
    @(posedge clk);
    #1;

    $display("[TB] flush overriding an accepted word");
    ia.flush    = 1'b1;
    ia.in_valid = 1'b1;
    ia.in_sel   = 3'd3;
    @(posedge clk);
    #1;
    ia.flush = 1'b0;
    idleInputs();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("a_flush_drop", ia.out_valid, 0);
    end
    checkOutput("a_flush_drop_data", ia.out_data, 8'h10);
    @(posedge clk);
    #1;
    applyStimulus(0, 3'd2, 8'h12, 3);
    idleInputs();
    waitCycles(5);

    $display("[TB] asynchronous reset with a full, stalled pipeline");
    ia.out_ready = 1'b0;
    applyStimulus(0, 3'd6, 8'h16, 0);
    applyStimulus(0, 3'd7, 8'h17, 0);
    applyStimulus(0, 3'd0, 8'h10, 0);
    idleInputs();
    checkOutput("a_full_before_reset", ia.out_valid, 1);
    arst_n = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    checkOutput("a_arst_out_valid", ia.out_valid, 0);
    checkOutput("a_arst_out_data",  ia.out_data,  0);
    checkOutput("a_arst_sel_err",   ia.sel_err,   0);
    checkOutput("b_arst_sel_err",   ib.sel_err,   0);
    #4;
    arst_n = 1'b1;
    @(negedge clk);
    checkOutput("a_arst_in_ready", ia.in_ready, 1);
    ia.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("a_arst_quiet", ia.out_valid, 0);
    end
    @(posedge clk);
    #1;
    applyStimulus(0, 3'd5, 8'h15, 3);
    idleInputs();
    waitCycles(6);

    checkOutput("a_queue_empty", qa.size(), 0);
    checkOutput("b_queue_empty", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
